serial_parity_checker: RTL

- Downstream consumer of the serial word stream and the parity_bit_gen output.
- Sits on the same data_in/wr_en stream that shift_reg drives into parity_bit_gen, and also takes the generator's parity bit.
- Deserializes each wr_en burst into a parallel word and recomputes parity locally.
- Flags parity and length errors with a one-cycle valid pulse, and keeps a saturating error count.

---
 rtl/serial_parity_checker.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/serial_parity_checker.sv
// serial_parity_checker: deserializes MSB-first wr_en bursts into a parallel
// word, recomputes parity over every received bit and compares it with the
// parity bit sampled in the first idle cycle after the burst. Each finished
// burst produces a one-cycle report with the word, parity/length error flags
// and a saturating error count.
//
// Stream semantics: wr_en qualifies data_in for exactly one cycle per bit;
// there is no back-pressure. The first cycle with wr_en=0 after a burst
// carries parity_in. word_valid pulses for one cycle when data_word,
// parity_err, len_err and err_cnt take their new values; those outputs then
// hold until the next report.
module serial_parity_checker #(
  parameter int NUM_BITS        = 4,
  parameter bit EVEN_PARITY_BIT = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                data_in,
  input  logic                wr_en,
  input  logic                parity_in,
  output logic [NUM_BITS-1:0] data_word,
  output logic                word_valid,
  output logic                parity_err,
  output logic                len_err,
  output logic [7:0]          err_cnt
);

  localparam int CW = $clog2(NUM_BITS + 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(NUM_BITS);
  localparam logic [CW-1:0] CNT_OVER = CW'(NUM_BITS + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_e;

  // state_q is the FSM debug hook: checkers may bind to it directly.
  state_e state_q, state_d;

  logic [NUM_BITS-1:0] shift_q, shift_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                acc_q, acc_d;
  logic [NUM_BITS-1:0] data_word_q, data_word_d;
  logic                word_valid_q, word_valid_d;
  logic                parity_err_q, parity_err_d;
  logic                len_err_q, len_err_d;
  logic [7:0]          err_cnt_q, err_cnt_d;

  // A burst may start from IDLE or directly in the REPORT cycle.
  logic start_word;
  logic end_word;
  logic [NUM_BITS:0] shift_ins;

  assign start_word = wr_en && (state_q != SHIFT);
  assign end_word   = !wr_en && (state_q == SHIFT);
  assign shift_ins  = {shift_q, data_in};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: REPORT lasts one cycle and can restart a burst.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (wr_en) state_d = SHIFT;
      SHIFT:   if (!wr_en) state_d = REPORT;
      REPORT:  state_d = wr_en ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and report next values; bits past NUM_BITS only feed parity.
  always_comb begin
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    data_word_d  = data_word_q;
    word_valid_d = 1'b0;
    parity_err_d = parity_err_q;
    len_err_d    = len_err_q;
    err_cnt_d    = err_cnt_q;

    if (start_word) begin
      shift_d    = '0;
      shift_d[0] = data_in;
      cnt_d      = CNT_ONE;
      acc_d      = data_in;
    end else if (state_q == SHIFT && wr_en) begin
      acc_d = acc_q ^ data_in;
      if (cnt_q < CNT_FULL) begin
        shift_d = shift_ins[NUM_BITS-1:0];
        cnt_d   = cnt_q + CNT_ONE;
      end else begin
        cnt_d = CNT_OVER;
      end
    end

    if (end_word) begin
      data_word_d  = shift_q;
      parity_err_d = parity_in != (acc_q ^ EVEN_PARITY_BIT);
      len_err_d    = cnt_q != CNT_FULL;
      word_valid_d = 1'b1;
      if ((parity_err_d || len_err_d) && err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q      <= '0;
      cnt_q        <= '0;
      acc_q        <= 1'b0;
      data_word_q  <= '0;
      word_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      len_err_q    <= 1'b0;
      err_cnt_q    <= 8'd0;
    end else begin
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      data_word_q  <= data_word_d;
      word_valid_q <= word_valid_d;
      parity_err_q <= parity_err_d;
      len_err_q    <= len_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign data_word  = data_word_q;
  assign word_valid = word_valid_q;
  assign parity_err = parity_err_q;
  assign len_err    = len_err_q;
  assign err_cnt    = err_cnt_q;

endmodule
